// File: rtl/onehotclk_async_write_ctrl_pkg.sv
// Shared one-hot-clock definitions: FSM encodings and counter width.
// The read-side control imports the same package, so the encodings stay in step.
package onehotclk_async_write_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] ohc_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAKE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } ohc_state_e;

  // Write side may run its clock unless one-hot DFT mode is selecting the read clock.
  function automatic logic dft_ok_w(input logic one_hot_enable, input logic tp);
    return !one_hot_enable || tp;
  endfunction

  // Reload value for a cycle budget; a zero budget never loads the counter.
  function automatic ohc_cnt_t cnt_load(input int unsigned cycles);
    return (cycles == 0) ? '0 : ohc_cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/onehotclk_async_write_ctrl.sv
// Write-side clock-gate control for an async FIFO: wakes the write clock on
// demand, accepts writes once awake, and holds the clock briefly after traffic stops.
module onehotclk_async_write_ctrl
  import onehotclk_async_write_ctrl_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  input  logic wr_req,
  output logic wr_ready,
  input  logic one_hot_enable,
  input  logic tp,
  output logic enable_w,
  output logic wr_idle
);

  localparam ohc_cnt_t WAKE_LOAD = cnt_load(WAKE_CYCLES);
  localparam ohc_cnt_t HOLD_LOAD = cnt_load(HOLD_CYCLES);

  ohc_state_e state, state_nxt;
  ohc_cnt_t   cnt, cnt_nxt;
  logic       dft_ok;
  logic       func_en;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // DFT inputs only gate the outputs; sequencing is identical in every mode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (wr_req) begin
          if (WAKE_CYCLES != 0) begin
            state_nxt = ST_WAKE;
            cnt_nxt   = WAKE_LOAD;
          end else begin
            state_nxt = ST_ACTIVE;
          end
        end
      end
      ST_WAKE: begin
        if (cnt != '0) cnt_nxt   = cnt - ohc_cnt_t'(1);
        else           state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!wr_req) begin
          if (HOLD_CYCLES != 0) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = HOLD_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (wr_req)          state_nxt = ST_ACTIVE;
        else if (cnt != '0)  cnt_nxt   = cnt - ohc_cnt_t'(1);
        else                 state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // enable_w must not see wr_req: it comes from registered state and static DFT pins.
  always_comb begin
    dft_ok   = dft_ok_w(one_hot_enable, tp);
    func_en  = (state != ST_IDLE);
    enable_w = func_en && dft_ok;
    wr_ready = wr_req && dft_ok && ((state == ST_ACTIVE) || (state == ST_HOLD));
    wr_idle  = (state == ST_IDLE);
  end

endmodule

// File: tb/tb_onehotclk_async_write_ctrl.sv
// Directed bench: one instance with default timing, one with zero wake/hold.
// Stimulus pushes per-cycle expectations; a negedge monitor pops and checks them.
module tb_onehotclk_async_write_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, req_z = 1'b0;
  logic ohe = 1'b0, tp = 1'b0;
  logic rdy_a, en_a, idle_a;
  logic rdy_z, en_z, idle_z;

  always #5 clk = ~clk;

  onehotclk_async_write_ctrl #(.WAKE_CYCLES(2), .HOLD_CYCLES(4)) dut_a (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n), .wr_req(req_a), .wr_ready(rdy_a),
    .one_hot_enable(ohe), .tp(tp), .enable_w(en_a), .wr_idle(idle_a));

  onehotclk_async_write_ctrl #(.WAKE_CYCLES(0), .HOLD_CYCLES(0)) dut_z (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n), .wr_req(req_z), .wr_ready(rdy_z),
    .one_hot_enable(ohe), .tp(tp), .enable_w(en_z), .wr_idle(idle_z));

  // Expected {enable_w, wr_ready, wr_idle}
  localparam logic [2:0] I = 3'b001;  // idle
  localparam logic [2:0] E = 3'b100;  // clock on, no accept
  localparam logic [2:0] R = 3'b110;  // clock on, write accepted
  localparam logic [2:0] O = 3'b000;  // busy but gated off by DFT

  typedef struct {
    string      tag;
    logic [2:0] a;
    logic [2:0] z;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_vec++;
      if ({en_a, rdy_a, idle_a} !== e.a) begin
        n_bad++;
        $display("FAIL %s dut_a {en,rdy,idle} got %b expected %b at %0t", e.tag,
                 {en_a, rdy_a, idle_a}, e.a, $time);
      end
      n_vec++;
      if ({en_z, rdy_z, idle_z} !== e.z) begin
        n_bad++;
        $display("FAIL %s dut_z {en,rdy,idle} got %b expected %b at %0t", e.tag,
                 {en_z, rdy_z, idle_z}, e.z, $time);
      end
    end
  end

  // One cycle: drive just after the rising edge, expectation checked at the falling edge.
  task automatic step(input string tag, input logic r, a, z, oh, t,
                      input logic [2:0] ea, ez);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; req_a = a; req_z = z; ohe = oh; tp = t;
    e.tag = tag; e.a = ea; e.z = ez;
    sb.push_back(e);
  endtask

  task automatic drain_hold(input string tag);
    for (int i = 0; i < 4; i++) step(tag, 1, 0, 0, 0, 0, E, I);
    step({tag, "_idle"}, 1, 0, 0, 0, 0, I, I);
  endtask

  initial begin
    // Reset holds IDLE, even with a request present across clock edges
    step("rst0", 0, 0, 0, 0, 0, I, I);
    step("rst_req", 0, 1, 1, 0, 0, I, I);
    step("rst_req2", 0, 1, 1, 0, 0, I, I);

    // Wake latency: request from cycle 0, first accept at cycle 3
    step("wake_c0", 1, 1, 0, 0, 0, I, I);
    step("wake_c1", 1, 1, 0, 0, 0, E, I);
    step("wake_c2", 1, 1, 0, 0, 0, E, I);
    step("wake_c3", 1, 1, 0, 0, 0, R, I);
    step("act_c4", 1, 1, 0, 0, 0, R, I);
    step("act_n", 1, 1, 0, 0, 0, R, I);
    step("act_drop", 1, 0, 0, 0, 0, E, I);
    drain_hold("hold");
    step("idle_stay", 1, 0, 0, 0, 0, I, I);

    // HOLD re-entry: request at N+3 accepted immediately
    step("re_c0", 1, 1, 0, 0, 0, I, I);
    step("re_c1", 1, 1, 0, 0, 0, E, I);
    step("re_c2", 1, 1, 0, 0, 0, E, I);
    step("re_n", 1, 1, 0, 0, 0, R, I);
    step("re_n1", 1, 0, 0, 0, 0, E, I);
    step("re_n2", 1, 0, 0, 0, 0, E, I);
    step("re_n3_hit", 1, 1, 0, 0, 0, R, I);
    step("re_n4_act", 1, 1, 0, 0, 0, R, I);
    step("re_drop", 1, 0, 0, 0, 0, E, I);
    drain_hold("re_hold");

    // Wake abort attempt: request drops during WAKE, still reaches ACTIVE
    step("ab_c0", 1, 1, 0, 0, 0, I, I);
    step("ab_c1", 1, 0, 0, 0, 0, E, I);
    step("ab_c2", 1, 0, 0, 0, 0, E, I);
    step("ab_act", 1, 0, 0, 0, 0, E, I);
    drain_hold("ab_hold");

    // DFT phases while ACTIVE with a request pending
    step("dft_c0", 1, 1, 0, 0, 0, I, I);
    step("dft_c1", 1, 1, 0, 0, 0, E, I);
    step("dft_c2", 1, 1, 0, 0, 0, E, I);
    step("dft_tp0", 1, 1, 0, 1, 0, O, I);
    step("dft_tp1", 1, 1, 0, 1, 1, R, I);
    step("dft_tp0b", 1, 1, 0, 1, 0, O, I);
    // Sequencing unchanged while gated: ACTIVE, four HOLD cycles, then IDLE
    step("dft_drop", 1, 0, 0, 1, 0, O, I);
    for (int i = 0; i < 4; i++) step("dft_hold", 1, 0, 0, 1, 0, O, I);
    step("dft_idle", 1, 0, 0, 1, 0, I, I);
    step("dft_off", 1, 0, 0, 0, 0, I, I);

    // Zero wake/hold: single-cycle request, then held request
    step("z_single", 1, 0, 1, 0, 0, I, I);
    step("z_act", 1, 0, 0, 0, 0, I, E);
    step("z_idle", 1, 0, 0, 0, 0, I, I);
    step("z_held0", 1, 0, 1, 0, 0, I, I);
    step("z_held1", 1, 0, 1, 0, 0, I, R);
    step("z_held2", 1, 0, 1, 0, 0, I, R);
    step("z_drop", 1, 0, 0, 0, 0, I, E);
    step("z_idle2", 1, 0, 0, 0, 0, I, I);

    // Reset asserted asynchronously right after WAKE with cnt=1 is entered
    step("mr_c0", 1, 1, 0, 0, 0, I, I);
    step("mr_c1", 1, 1, 0, 0, 0, E, I);
    step("mr_c0b", 1, 1, 0, 0, 0, E, I);
    step("mr_c0c", 1, 1, 0, 0, 0, R, I);
    step("mr_drop", 1, 0, 0, 0, 0, E, I);
    drain_hold("mr_pre");
    step("mr_w0", 1, 1, 1, 0, 0, I, I);
    step("mr_rst", 0, 1, 1, 0, 0, I, I);
    step("mr_rst2", 0, 1, 1, 0, 0, I, I);
    step("mr_rel0", 1, 1, 0, 0, 0, I, I);
    step("mr_rel1", 1, 1, 0, 0, 0, E, I);
    step("mr_rel2", 1, 1, 0, 0, 0, E, I);
    step("mr_rel3", 1, 1, 0, 0, 0, R, I);
    step("mr_drop2", 1, 0, 0, 0, 0, E, I);
    drain_hold("mr_hold");

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain scoreboard left %0d entries, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/onehotclk_async_write_ctrl.md
ONEHOTCLK_ASYNC_WRITE_CTRL -- requirements
Module: oneHotClk_async_write_ctrl

Interface
REQ-001 The block SHALL have a parameter WAKE_CYCLES, default 2, giving the cycles between clock-enable assertion and the first write acceptance (0..15).
REQ-002 The block SHALL have a parameter HOLD_CYCLES, default 4, giving the cycles the clock stays enabled after the last write request (0..15).
REQ-003 The block SHALL have the port nvdla_core_clk, input, 1 bit: the single clock; all state is in this domain.
REQ-004 The block SHALL have the port nvdla_core_rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have the port wr_req, input, 1 bit: the producer requests an async-FIFO write this cycle.
REQ-006 The block SHALL have the port wr_ready, output, 1 bit: the write is accepted this cycle.
REQ-007 The block SHALL have the port one_hot_enable, input, 1 bit: DFT one-hot-clock mode; tied 0 in functional mode.
REQ-008 The block SHALL have the port tp, input, 1 bit: DFT test phase; 1 selects the write clock and 0 selects the read clock.
REQ-009 The block SHALL have the port enable_w, output, 1 bit: the enable to the write-side clock gate.
REQ-010 The block SHALL have the port wr_idle, output, 1 bit: high when the FSM is in IDLE.

Function
REQ-011 dft_ok SHALL be defined as (!one_hot_enable || tp), the write-side counterpart of the read-side enable.
REQ-012 func_en SHALL be defined as (state != IDLE).
REQ-013 enable_w SHALL equal func_en && dft_ok.
- It is decoded from registered state plus the static DFT inputs only.
- No combinational path from wr_req to enable_w is allowed.
REQ-014 The FSM SHALL have the states IDLE, WAKE, ACTIVE and HOLD, plus a 4-bit down-counter cnt.
REQ-015 IDLE transitions:
- wr_req=1 and WAKE_CYCLES>0 -> WAKE, with cnt=WAKE_CYCLES-1.
- wr_req=1 and WAKE_CYCLES=0 -> ACTIVE.
- Otherwise stay in IDLE.
REQ-016 WAKE transitions:
- cnt!=0 -> decrement cnt.
- cnt=0 -> ACTIVE.
- wr_req is ignored in WAKE.
REQ-017 ACTIVE transitions:
- wr_req=1 -> stay in ACTIVE.
- wr_req=0 and HOLD_CYCLES>0 -> HOLD, with cnt=HOLD_CYCLES-1.
- wr_req=0 and HOLD_CYCLES=0 -> IDLE.
REQ-018 HOLD transitions:
- wr_req=1 -> ACTIVE, with wr_ready asserted in the same cycle.
- Else cnt!=0 -> decrement cnt.
- Else (cnt=0) -> IDLE.
REQ-019 wr_ready SHALL equal wr_req && dft_ok && (state==ACTIVE || state==HOLD); it is never asserted in IDLE or WAKE.
REQ-020 A request held continuously from IDLE SHALL see its first wr_ready exactly WAKE_CYCLES+1 cycles after wr_req rises.
REQ-021 After the last ACTIVE cycle with wr_req=1, the FSM SHALL remain in HOLD for exactly HOLD_CYCLES cycles before entering IDLE.
REQ-022 With dft_ok=0, the state and cnt sequencing SHALL be unchanged, while enable_w=0 and wr_ready=0.
REQ-023 wr_req deasserting during WAKE SHALL NOT abort the wake; the FSM reaches ACTIVE and then follows REQ-017.

Reset
REQ-024 While nvdla_core_rstn=0, the block SHALL hold state=IDLE and cnt=0.
- It SHALL therefore drive enable_w=0, wr_ready=0 and wr_idle=1, independent of the clock.
REQ-025 Reset asserted mid-operation in any state SHALL return the block to IDLE immediately.
- The first cycle after release behaves as IDLE.

Structure
REQ-026 The state encodings (2-bit IDLE=0, WAKE=1, ACTIVE=2, HOLD=3) and the 4-bit counter width SHALL be defined in the shared oneHotClk definitions include, which is also used by the read-side logic.
REQ-027 The block SHALL be one flat module with no sub-modules.
- The DFT inputs SHALL be ports, not internal sources, so the block can be verified standalone.

Verification (WAKE_CYCLES=2, HOLD_CYCLES=4 unless stated)
REQ-028 Wake latency:
- Stimulus: reset released; wr_req=1 from cycle 0.
- Response: enable_w=1 from cycle 1; first wr_ready at cycle 3; wr_ready=1 every cycle thereafter.
REQ-029 Hold window:
- Stimulus: last wr_req=1 at cycle N while in ACTIVE.
- Response: HOLD at N+2..N+5; enable_w=1 through N+5; IDLE with enable_w=0 and wr_idle=1 at N+6.
REQ-030 HOLD re-entry:
- Stimulus: wr_req=1 at N+3 during HOLD.
- Response: wr_ready=1 at N+3 with no wake delay; state=ACTIVE at N+4.
REQ-031 DFT phases:
- Stimulus: one_hot_enable=1 with tp=0 in ACTIVE with wr_req=1.
- Response: enable_w=0 and wr_ready=0.
- Stimulus: the same with tp=1.
- Response: enable_w=1 and wr_ready=1.
REQ-032 Zero parameters:
- Stimulus: WAKE_CYCLES=0 and HOLD_CYCLES=0; a single-cycle wr_req at cycle 0.
- Response: wr_ready first at cycle 1 if wr_req is still high; IDLE the cycle after wr_req drops in ACTIVE.
REQ-033 Reset mid-operation:
- Stimulus: nvdla_core_rstn asserted low asynchronously during WAKE with cnt=1.
- Response: enable_w=0 immediately; after release with wr_req=1, the full WAKE_CYCLES+1 latency repeats.
